// File: rtl/subvec_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module   : subvec_assembler_if
//  Brief    : Sub-vector input stream and assembled-vector output bundle.
//             The slave modport is the assembler's view, the master modport
//             is the view of the block driving it (upstream + downstream).
//  Revision : 1.0  initial release
// ============================================================================
interface subvec_assembler_if #(
  parameter int VECTOR_WIDTH = 920,
  parameter int BUS_WIDTH    = 128,
  parameter int VEC_ID_WIDTH = 16,
  parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH)
);
  logic [BUS_WIDTH-1:0]    up_SubVector;
  logic [VEC_ID_WIDTH-1:0] up_ID;
  logic                    up_Valid;
  logic [CNT_WIDTH-1:0]    up_Cnt;
  logic                    up_CntNew;
  logic                    up_Last;
  logic                    up_Ready;
  logic [VECTOR_WIDTH-1:0] dn_Vector;
  logic [VEC_ID_WIDTH-1:0] dn_ID;
  logic [CNT_WIDTH-1:0]    dn_Cnt;
  logic                    dn_Last;
  logic                    dn_Valid;
  logic                    dn_Ready;
  logic                    err_Frame;

  modport slave (
    input  up_SubVector, up_ID, up_Valid, up_Cnt, up_CntNew, up_Last, dn_Ready,
    output up_Ready, dn_Vector, dn_ID, dn_Cnt, dn_Last, dn_Valid, err_Frame
  );

  modport master (
    output up_SubVector, up_ID, up_Valid, up_Cnt, up_CntNew, up_Last, dn_Ready,
    input  up_Ready, dn_Vector, dn_ID, dn_Cnt, dn_Last, dn_Valid, err_Frame
  );
endinterface
`default_nettype wire

// File: rtl/subvec_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : subvec_assembler
//  Brief    : Reassembles BUS_WIDTH sub-vector words into full VECTOR_WIDTH
//             vectors with ID and ones-count; double-buffered so one vector
//             assembles while the previous one waits at the output.
//  Revision : 1.0  initial release
// ============================================================================
module subvec_assembler #(
  parameter int VECTOR_WIDTH = 920,
  parameter int BUS_WIDTH    = 128,
  parameter int VEC_ID_WIDTH = 16,
  parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH)
) (
  input  logic               clk,
  input  logic               rstn,
  subvec_assembler_if.slave  bus
);

  localparam int c_SUB_NO    = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int c_LAST_BITS = VECTOR_WIDTH - (c_SUB_NO - 1) * BUS_WIDTH;
  localparam int c_CW        = (c_SUB_NO > 1) ? $clog2(c_SUB_NO) : 1;
  localparam logic [c_CW-1:0] c_LAST_IDX = c_CW'(c_SUB_NO - 1);

  localparam logic [0:0] c_S_EMPTY = 1'b0;
  localparam logic [0:0] c_S_HOLD  = 1'b1;

  // assembly buffer
  logic [c_CW-1:0]         r_wcnt;
  logic [VECTOR_WIDTH-1:0] r_asm;
  logic [VEC_ID_WIDTH-1:0] r_asm_id;
  logic [CNT_WIDTH-1:0]    r_asm_cnt;
  logic                    r_asm_last;
  logic                    r_full;

  // output stage
  logic [0:0]              r_state;
  logic [VECTOR_WIDTH-1:0] r_dn_vector;
  logic [VEC_ID_WIDTH-1:0] r_dn_id;
  logic [CNT_WIDTH-1:0]    r_dn_cnt;
  logic                    r_dn_last;
  logic                    r_err;

  logic                    w_drain;
  logic                    w_accept;
  logic                    w_close;
  logic                    w_first;
  logic                    w_at_last;
  logic                    w_wr;
  logic                    w_frame_bad;
  logic [VECTOR_WIDTH-1:0] w_asm_next;
  logic [VEC_ID_WIDTH-1:0] w_id_next;

  assign w_drain   = (r_state == c_S_HOLD) && bus.dn_Ready;
  assign bus.up_Ready = !(r_full && !w_drain);
  assign w_accept  = bus.up_Valid && bus.up_Ready;
  assign w_close   = w_accept && bus.up_CntNew;
  assign w_first   = (r_wcnt == '0);
  assign w_at_last = (r_wcnt == c_LAST_IDX);
  // A non-closing word beyond the last slot is dropped rather than written.
  assign w_wr      = w_accept && !(w_at_last && !bus.up_CntNew);
  assign w_id_next = w_first ? bus.up_ID : r_asm_id;

  assign w_frame_bad = w_accept && (
                         ( bus.up_CntNew && !w_at_last) ||
                         (!bus.up_CntNew &&  w_at_last) ||
                         (!w_first && (bus.up_ID != r_asm_id)));

  // Next assembly image: clear on a vector's first word, then drop the word
  // into its slot (last slot keeps only the bits that fit the vector).
  always_comb begin
    w_asm_next = w_first ? '0 : r_asm;
    for (int k = 0; k < c_SUB_NO - 1; k++) begin
      if (r_wcnt == c_CW'(k)) begin
        w_asm_next[k*BUS_WIDTH +: BUS_WIDTH] = bus.up_SubVector;
      end
    end
    if (w_at_last) begin
      w_asm_next[VECTOR_WIDTH-1 -: c_LAST_BITS] = bus.up_SubVector[c_LAST_BITS-1:0];
    end
  end

  // Word counter and assembly buffer update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wcnt     <= '0;
      r_asm      <= '0;
      r_asm_id   <= '0;
      r_asm_cnt  <= '0;
      r_asm_last <= 1'b0;
    end else begin
      if (w_accept) begin
        if (bus.up_CntNew) begin
          r_wcnt <= '0;
        end else if (!w_at_last) begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end
      if (w_wr) begin
        r_asm    <= w_asm_next;
        r_asm_id <= w_id_next;
      end
      if (w_close) begin
        r_asm_cnt  <= bus.up_Cnt;
        r_asm_last <= bus.up_Last;
      end
    end
  end

  // Output stage: load a waiting vector first, else one closing this cycle;
  // a close while the output is stuck parks the vector in assembly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= c_S_EMPTY;
      r_full      <= 1'b0;
      r_dn_vector <= '0;
      r_dn_id     <= '0;
      r_dn_cnt    <= '0;
      r_dn_last   <= 1'b0;
    end else if ((r_state == c_S_EMPTY) || w_drain) begin
      if (r_full) begin
        r_state     <= c_S_HOLD;
        r_full      <= w_close;
        r_dn_vector <= r_asm;
        r_dn_id     <= r_asm_id;
        r_dn_cnt    <= r_asm_cnt;
        r_dn_last   <= r_asm_last;
      end else if (w_close) begin
        r_state     <= c_S_HOLD;
        r_dn_vector <= w_asm_next;
        r_dn_id     <= w_id_next;
        r_dn_cnt    <= bus.up_Cnt;
        r_dn_last   <= bus.up_Last;
      end else begin
        r_state <= c_S_EMPTY;
      end
    end else if (w_close) begin
      r_full <= 1'b1;
    end
  end

  // Sticky framing error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_frame_bad) begin
      r_err <= 1'b1;
    end
  end

  assign bus.dn_Valid  = (r_state == c_S_HOLD);
  assign bus.dn_Vector = r_dn_vector;
  assign bus.dn_ID     = r_dn_id;
  assign bus.dn_Cnt    = r_dn_cnt;
  assign bus.dn_Last   = r_dn_last;
  assign bus.err_Frame = r_err;

endmodule
`default_nettype wire

// File: tb/tb_subvec_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_subvec_assembler
//  Brief    : Directed bench for subvec_assembler with an expected-vector
//             queue filled as vectors are sent and drained by a monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_subvec_assembler;
  localparam int VW = 920;
  localparam int BW = 128;
  localparam int IW = 16;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  subvec_assembler_if #(.VECTOR_WIDTH(VW), .BUS_WIDTH(BW), .VEC_ID_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

  subvec_assembler #(.VECTOR_WIDTH(VW), .BUS_WIDTH(BW), .VEC_ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [VW-1:0] v;
    logic [IW-1:0] id;
    logic [CW-1:0] c;
    logic          l;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   cyc    = 0;
  int   total  = 0;
  int   bad    = 0;
  int   stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every output handshake is compared against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.dn_Valid && bus.dn_Ready) begin
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_output observed_id=%0h expected=none", bus.dn_ID);
      end else begin
        e = sb.pop_front();
        for (int k = 0; k < 7; k++)
          check($sformatf("vec_w%0d", k), bus.dn_Vector[k*BW +: BW], e.v[k*BW +: BW]);
        check("vec_w7", 128'(bus.dn_Vector[VW-1 -: 24]), 128'(e.v[VW-1 -: 24]));
        check("dn_ID", 128'(bus.dn_ID), 128'(e.id));
        check("dn_Cnt", 128'(bus.dn_Cnt), 128'(e.c));
        check("dn_Last", 128'(bus.dn_Last), 128'(e.l));
      end
    end
  end

  task automatic send_word(input logic [BW-1:0] d, input logic [IW-1:0] id,
                           input logic cn, input logic [CW-1:0] c, input logic l);
    int waited;
    waited = 0;
    bus.up_Valid     = 1'b1;
    bus.up_SubVector = d;
    bus.up_ID        = id;
    bus.up_CntNew    = cn;
    bus.up_Cnt       = c;
    bus.up_Last      = l;
    @(negedge clk);
    while (!bus.up_Ready && waited < 50) begin
      waited++;
      stalls++;
      @(negedge clk);
    end
    if (!bus.up_Ready) begin
      total++;
      bad++;
      $error("FAIL accept_timeout observed=not_ready expected=ready");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.up_Valid  = 1'b0;
    bus.up_CntNew = 1'b0;
    bus.up_Last   = 1'b0;
  endtask

  // Sends n words (byte pattern base+i), CntNew on the last; word bad_idx
  // carries id+1. Expected vector is built from the words sent.
  task automatic send_vec(input logic [IW-1:0] id, input int n, input logic [CW-1:0] c,
                          input logic l, input int bad_idx, input logic [7:0] base);
    exp_t e;
    logic [BW-1:0] w;
    logic [7:0] b;
    e.v = '0; e.id = id; e.c = c; e.l = l;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      w = {16{b}};
      if (i < 7) e.v[i*BW +: BW] = w;
      else       e.v[VW-1 -: 24] = w[23:0];
      if (i == n - 1) sb.push_back(e);
      send_word(w, (i == bad_idx) ? id + 16'h1 : id, (i == n - 1), c, l);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    int d1, d2;
    rstn = 1'b0;
    bus.up_SubVector = '0; bus.up_ID = '0; bus.up_Cnt = '0;
    bus.dn_Ready = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dn_Valid", 128'(bus.dn_Valid), 128'(0));
    check("rst_err", 128'(bus.err_Frame), 128'(0));
    check("rst_up_Ready", 128'(bus.up_Ready), 128'(1));
    check("rst_dn_ID", 128'(bus.dn_ID), 128'(0));
    check("rst_dn_Cnt", 128'(bus.dn_Cnt), 128'(0));
    check("rst_vec_lo", bus.dn_Vector[127:0], 128'(0));
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Basic 8-word vector, output visible right after the closing edge.
    bus.dn_Ready = 1'b1;
    send_vec(16'h0042, 8, 10'h123, 1'b0, -1, 8'h01);
    idle();
    check("t1_valid", 128'(bus.dn_Valid), 128'(1));
    check("t1_id", 128'(bus.dn_ID), 128'(16'h0042));
    check("t1_cnt", 128'(bus.dn_Cnt), 128'(10'h123));
    check("t1_vec_lo", bus.dn_Vector[127:0], {16{8'h01}});
    check("t1_vec_hi", 128'(bus.dn_Vector[919:896]), 128'(24'h080808));
    check("t1_err", 128'(bus.err_Frame), 128'(0));
    wait_drain();

    // Two vectors with downstream stalled: second parks in assembly.
    bus.dn_Ready = 1'b0;
    stalls = 0;
    send_vec(16'h0100, 8, 10'h011, 1'b0, -1, 8'h10);
    send_vec(16'h0101, 8, 10'h022, 1'b0, -1, 8'h20);
    idle();
    check("t2_ready_low", 128'(bus.up_Ready), 128'(0));
    check("t2_stalls", 128'(stalls), 128'(0));
    check("t2_hold_id", 128'(bus.dn_ID), 128'(16'h0100));
    @(posedge clk); #1;
    check("t2_hold_id2", 128'(bus.dn_ID), 128'(16'h0100));
    check("t2_ready_low2", 128'(bus.up_Ready), 128'(0));
    bus.dn_Ready = 1'b1;
    #1;
    check("t2_ready_drain", 128'(bus.up_Ready), 128'(1));
    @(posedge clk); #1;
    bus.dn_Ready = 1'b0;
    #1;
    check("t2_second_valid", 128'(bus.dn_Valid), 128'(1));
    check("t2_second_id", 128'(bus.dn_ID), 128'(16'h0101));
    check("t2_ready_high", 128'(bus.up_Ready), 128'(1));
    bus.dn_Ready = 1'b1;
    wait_drain();

    // Three vectors streamed with no gaps: outputs 8 cycles apart.
    stalls = 0;
    hs_cyc.delete();
    send_vec(16'h0200, 8, 10'h001, 1'b0, -1, 8'h30);
    send_vec(16'h0201, 8, 10'h002, 1'b0, -1, 8'h40);
    send_vec(16'h0202, 8, 10'h003, 1'b0, -1, 8'h50);
    idle();
    wait_drain();
    check("t3_pulses", 128'(hs_cyc.size()), 128'(3));
    d1 = (hs_cyc.size() >= 2) ? hs_cyc[1] - hs_cyc[0] : -1;
    d2 = (hs_cyc.size() >= 3) ? hs_cyc[2] - hs_cyc[1] : -1;
    check("t3_gap1", 128'(d1), 128'(8));
    check("t3_gap2", 128'(d2), 128'(8));
    check("t3_stalls", 128'(stalls), 128'(0));

    // Short vector: closes on word 4, missing words read zero, error sticks.
    send_vec(16'h0300, 5, 10'h015, 1'b0, -1, 8'h60);
    idle();
    check("t4_err", 128'(bus.err_Frame), 128'(1));
    check("t4_w5_zero", bus.dn_Vector[5*BW +: BW], 128'(0));
    wait_drain();
    send_vec(16'h0301, 8, 10'h016, 1'b0, -1, 8'h68);
    idle();
    wait_drain();
    check("t4_err_sticky", 128'(bus.err_Frame), 128'(1));

    // Reset mid-vector while a vector is held at the output.
    bus.dn_Ready = 1'b0;
    send_vec(16'h0400, 8, 10'h040, 1'b0, -1, 8'h70);
    idle();
    for (int i = 0; i < 4; i++) begin
      send_word({16{8'h80 + 8'(i)}}, 16'h0401, 1'b0, 10'h0, 1'b0);
    end
    idle();
    rstn = 1'b0;
    #1;
    check("t6_rst_valid", 128'(bus.dn_Valid), 128'(0));
    check("t6_rst_err", 128'(bus.err_Frame), 128'(0));
    check("t6_rst_id", 128'(bus.dn_ID), 128'(0));
    check("t6_rst_ready", 128'(bus.up_Ready), 128'(1));
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    bus.dn_Ready = 1'b1;
    @(posedge clk); #1;
    send_vec(16'h0402, 8, 10'h3FF, 1'b1, -1, 8'h90);
    idle();
    check("t6_last", 128'(bus.dn_Last), 128'(1));
    check("t6_cnt", 128'(bus.dn_Cnt), 128'(10'h3FF));
    wait_drain();

    // ID mismatch on word 3.
    check("t5_err_before", 128'(bus.err_Frame), 128'(0));
    send_vec(16'h0042, 8, 10'h055, 1'b0, 3, 8'hA0);
    idle();
    check("t5_err", 128'(bus.err_Frame), 128'(1));
    check("t5_id", 128'(bus.dn_ID), 128'(16'h0042));
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
